// File: rtl/axis_beat_packer_pkg.sv
// Shared constants, state encoding and helpers for the AXI-stream beat packer.
package axis_pack_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int NUM_DATA   = 32;
  localparam int BUS_W      = DATA_WIDTH * NUM_DATA;
  localparam int CNT_W      = 7;

  // Byte count of one full output beat, at counter width.
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_DATA);

  typedef enum logic {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Low n lanes set; any n >= NUM_DATA yields all ones.
  function automatic logic [NUM_DATA-1:0] therm(input logic [CNT_W-1:0] n);
    logic [NUM_DATA-1:0] t;
    t = '0;
    for (int i = 0; i < NUM_DATA; i++) begin
      t[i] = (CNT_W'(i) < n);
    end
    return t;
  endfunction

endpackage

// File: rtl/axis_beat_packer_if.sv
// Upstream and downstream AXI-stream signals of the beat packer.
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; a producer holding valid keeps data/keep/last stable until the transfer.
interface axis_beat_packer_if;
  import axis_pack_pkg::*;

  logic [BUS_W-1:0]    data_in;
  logic                tvalid_in;
  logic                tlast_in;
  logic [NUM_DATA-1:0] tkeep_in;
  logic                tready_in;
  logic [BUS_W-1:0]    data_out;
  logic                tvalid_out;
  logic                tlast_out;
  logic [NUM_DATA-1:0] tkeep_out;
  logic                tready_out;

  // Packer view.
  modport slave (
    input  data_in, tvalid_in, tlast_in, tkeep_in, tready_in,
    output data_out, tvalid_out, tlast_out, tkeep_out, tready_out
  );

  // Environment view: drives the upstream beat and downstream ready.
  modport master (
    output data_in, tvalid_in, tlast_in, tkeep_in, tready_in,
    input  data_out, tvalid_out, tlast_out, tkeep_out, tready_out
  );

endinterface

// File: rtl/axis_beat_packer_keep_to_count.sv
// Contiguous byte-enable mask to byte count (index of the first cleared lane).
module keep_to_count
  import axis_pack_pkg::*;
(
  input  logic [NUM_DATA-1:0] keep,
  output logic [5:0]          k
);

  // Scan from the top lane down so the lowest cleared lane wins.
  always_comb begin
    k = 6'd32;
    for (int i = NUM_DATA - 1; i >= 0; i--) begin
      if (!keep[i]) k = 6'(i);
    end
  end

endmodule

// File: rtl/axis_beat_packer.sv
// Re-packs sparse per-packet AXI-stream bytes into dense 32-byte beats.
// A 64-lane buffer collects bytes; lanes 0..31 form the outgoing beat.
module axis_beat_packer
  import axis_pack_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  axis_beat_packer_if.slave  bus,
  output state_t             state_dbg
);

  logic [2*NUM_DATA-1:0][DATA_WIDTH-1:0] buffer_q, buffer_d, shifted;
  logic [NUM_DATA-1:0][DATA_WIDTH-1:0]   lanes_in, lanes_out;
  logic [CNT_W-1:0]                      count_q, count_d, base;
  logic [NUM_DATA-1:0]                   keep_out;
  logic [5:0]                            k;
  state_t                                state_q, state_d;
  logic                                  empty_q, empty_d;
  logic                                  tready, tvalid, tlast, fire, accept;

  keep_to_count u_keep_to_count (
    .keep (bus.tkeep_in),
    .k    (k)
  );

  assign lanes_in  = bus.data_in;
  assign keep_out  = therm(count_q);
  assign state_dbg = state_q;

  // Handshake decode, counter and state next-values.
  // tready in ACCUM passes tready_in straight through so a fire frees space
  // in the same cycle, giving one beat per cycle inside a packet.
  always_comb begin
    state_d = state_q;
    empty_d = empty_q;
    tready  = 1'b0;
    tvalid  = 1'b0;
    tlast   = 1'b0;
    case (state_q)
      ACCUM: begin
        tready = (count_q <= FULL_CNT) | bus.tready_in;
        tvalid = (count_q > FULL_CNT);
      end
      FLUSH: begin
        tvalid = (count_q != '0) | empty_q;
        tlast  = (count_q <= FULL_CNT);
      end
      default: ;
    endcase
    if (reset) begin
      tready = 1'b0;
      tvalid = 1'b0;
    end
    fire   = tvalid & bus.tready_in;
    accept = bus.tvalid_in & tready;
    base   = fire ? (count_q - FULL_CNT) : count_q;
    count_d = accept ? (base + CNT_W'(k)) : base;
    if (fire && tlast) begin
      count_d = '0;
      state_d = ACCUM;
      empty_d = 1'b0;
    end else if (accept && bus.tlast_in) begin
      state_d = FLUSH;
      empty_d = (count_d == '0);
    end
  end

  // Buffer next-value: drop the emitted beat, then insert accepted bytes at base.
  always_comb begin
    shifted  = fire ? {{BUS_W{1'b0}}, buffer_q[2*NUM_DATA-1:NUM_DATA]} : buffer_q;
    buffer_d = shifted;
    for (int i = 0; i < 2 * NUM_DATA; i++) begin
      if (accept && (CNT_W'(i) >= base) && (CNT_W'(i) < base + CNT_W'(k))) begin
        buffer_d[i] = lanes_in[5'(CNT_W'(i) - base)];
      end
    end
  end

  // Output lanes beyond the kept count are forced to zero.
  always_comb begin
    lanes_out = '0;
    for (int i = 0; i < NUM_DATA; i++) begin
      if (keep_out[i]) lanes_out[i] = buffer_q[i];
    end
  end

  // State, counter and buffer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ACCUM;
      count_q  <= '0;
      buffer_q <= '0;
      empty_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      buffer_q <= buffer_d;
      empty_q  <= empty_d;
    end
  end

  assign bus.tready_out = tready;
  assign bus.tvalid_out = tvalid;
  assign bus.tlast_out  = tlast;
  assign bus.tkeep_out  = keep_out;
  assign bus.data_out   = lanes_out;

endmodule
